// File: rtl/ls74163_divider_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ls74163_pkg
// Shared definitions for the LS74163 divider controller: the controller
// state encoding, the width of one counter stage and the width of the
// completed-period counter.
// ---------------------------------------------------------------------------
package ls74163_pkg;

  // Width of one LS74163 counter (QD..QA).
  localparam int STAGE_W   = 4;

  // Width of the saturating completed-period counter.
  localparam int PERIODS_W = 8;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } ctrl_state_e;

endpackage : ls74163_pkg

// File: rtl/ls74163_divider_ctrl_if.sv
// ---------------------------------------------------------------------------
// ls74163_divider_ctrl_if
// Bundles the sequencer-facing and counter-facing signals of the divider
// controller.
//   slave  : the controller (consumes START/STOP/MODE_ONESHOT/PRESET and the
//            counter outputs Q; drives the counter controls and status).
//   master : the environment (system sequencer plus the counter chain).
// Signals:
//   START, STOP, MODE_ONESHOT, PRESET[W]  sequencer requests
//   Q[W]                                  counter outputs, stage k = Q[4k+3:4k]
//   CLR_L, LD_L, LOAD_D[W], ENP, ENT[STAGES]  counter controls
//   TC, BUSY, DONE, PERIODS[8]            status
// ---------------------------------------------------------------------------
interface ls74163_divider_ctrl_if #(
  parameter int STAGES = 2
);
  import ls74163_pkg::*;

  localparam int W = STAGE_W * STAGES;

  logic                 START;
  logic                 STOP;
  logic                 MODE_ONESHOT;
  logic [W-1:0]         PRESET;
  logic [W-1:0]         Q;
  logic                 CLR_L;
  logic                 LD_L;
  logic [W-1:0]         LOAD_D;
  logic                 ENP;
  logic [STAGES-1:0]    ENT;
  logic                 TC;
  logic                 BUSY;
  logic                 DONE;
  logic [PERIODS_W-1:0] PERIODS;

  modport slave (
    input  START, STOP, MODE_ONESHOT, PRESET, Q,
    output CLR_L, LD_L, LOAD_D, ENP, ENT, TC, BUSY, DONE, PERIODS
  );

  modport master (
    output START, STOP, MODE_ONESHOT, PRESET, Q,
    input  CLR_L, LD_L, LOAD_D, ENP, ENT, TC, BUSY, DONE, PERIODS
  );

endinterface : ls74163_divider_ctrl_if

// File: rtl/ls74163_divider_ctrl_carry_chain.sv
// ---------------------------------------------------------------------------
// ls74163_carry_chain
// Purely combinational carry logic for a cascade of STAGES 4-bit counters.
// Ports:
//   q[4*STAGES]    counter outputs, stage k = q[4k+3:4k]
//   en             enables the chain (ENT[0]); 0 forces every ENT low
//   ent[STAGES]    per-stage carry enables; stage k counts only when all
//                  lower stages read 4'hF
//   all_ones       the whole cascade reads all ones (terminal count)
// ---------------------------------------------------------------------------
module ls74163_carry_chain
  import ls74163_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic [STAGE_W*STAGES-1:0] q,
  input  logic                      en,
  output logic [STAGES-1:0]         ent,
  output logic                      all_ones
);

  logic [STAGES-1:0] stage_ones;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign stage_ones[k] = &q[k*STAGE_W +: STAGE_W];
  end

  // A running term is used instead of reading ent[k-1] back, so the loop
  // does not form a combinational self-dependency on the ent vector.
  always_comb begin
    logic carry;
    carry = en;
    for (int k = 0; k < STAGES; k++) begin
      ent[k] = carry;
      carry  = carry & stage_ones[k];
    end
  end

  assign all_ones = &stage_ones;

endmodule : ls74163_carry_chain

// File: rtl/ls74163_divider_ctrl.sv
// ---------------------------------------------------------------------------
// ls74163_divider_ctrl
// Control stage for a cascade of STAGES LS74163 synchronous counters used as
// a programmable mod-N divider / timer. Period length is 2^W - preset cycles
// (W = 4*STAGES); TC pulses on the all-ones cycle of every period.
// Ports:
//   CLK       rising-edge clock shared with the counter chain
//   RESET_L   asynchronous active-low reset
//   bus       ls74163_divider_ctrl_if.slave (requests, counter Q in;
//             CLR_L/LD_L/LOAD_D/ENP/ENT, TC/BUSY/DONE/PERIODS out)
// Configuration:
//   LS74163_CTRL_ONESHOT_EN  defined  : MODE_ONESHOT=1 stops after one period
//                                       and parks in DONE.
//                            undefined: MODE_ONESHOT ignored, always
//                                       periodic, DONE tied low.
// ---------------------------------------------------------------------------
module ls74163_divider_ctrl
  import ls74163_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET_L,
  ls74163_divider_ctrl_if.slave  bus
);

  localparam int W = STAGE_W * STAGES;

  ctrl_state_e          state_q,   state_d;
  logic [W-1:0]         preset_q,  preset_d;
  logic [PERIODS_W-1:0] periods_q, periods_d;

  logic                 clr_l;
  logic                 ld_l;
  logic                 enp;
  logic [STAGES-1:0]    ent;
  logic                 tc;
  logic                 busy;
  logic                 done;

  logic [STAGES-1:0]    ent_chain;
  logic                 all_ones;
  logic                 oneshot;

  function automatic logic [PERIODS_W-1:0] sat_inc(input logic [PERIODS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef LS74163_CTRL_ONESHOT_EN
  assign oneshot = bus.MODE_ONESHOT;
`else
  logic unused_mode_oneshot;
  assign unused_mode_oneshot = bus.MODE_ONESHOT;
  assign oneshot             = 1'b0;
`endif

  ls74163_carry_chain #(
    .STAGES (STAGES)
  ) u_carry_chain (
    .q        (bus.Q),
    .en       (state_q == S_RUN),
    .ent      (ent_chain),
    .all_ones (all_ones)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= S_CLEAR;
      preset_q  <= '0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      periods_q <= periods_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    periods_d = periods_q;
    clr_l     = 1'b1;
    ld_l      = 1'b1;
    enp       = 1'b0;
    ent       = '0;
    tc        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_CLEAR: begin
        clr_l   = 1'b0;
        state_d = S_IDLE;
      end

      S_IDLE: begin
        if (bus.START && !bus.STOP) begin
          preset_d = bus.PRESET;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_l      = 1'b0;
        busy      = 1'b1;
        periods_d = '0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        enp  = 1'b1;
        ent  = ent_chain;
        if (all_ones) begin
          tc        = 1'b1;
          periods_d = sat_inc(periods_q);
          if (oneshot) begin
            // Freeze the chain on all ones; DONE holds it there.
            enp     = 1'b0;
            state_d = S_DONE;
          end else begin
            // Reload on the next edge so the period restarts seamlessly.
            ld_l = 1'b0;
          end
        end
      end

`ifdef LS74163_CTRL_ONESHOT_EN
      S_DONE: begin
        done = 1'b1;
        if (bus.START && !bus.STOP) begin
          preset_d = bus.PRESET;
          state_d  = S_LOAD;
        end
      end
`endif

      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // STOP wins over START and over the terminal transition.
    if (bus.STOP && (state_q != S_CLEAR)) begin
      state_d = S_CLEAR;
    end
  end

  assign bus.CLR_L   = clr_l;
  assign bus.LD_L    = ld_l;
  assign bus.LOAD_D  = preset_q;
  assign bus.ENP     = enp;
  assign bus.ENT     = ent;
  assign bus.TC      = tc;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.PERIODS = periods_q;

endmodule : ls74163_divider_ctrl

// File: tb/tb_ls74163_divider_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ls74163_divider_ctrl
// Drives the controller against two behavioural LS74163 counter stages and
// compares every RUN cycle against an arithmetic timeline of the expected
// counter value, terminal pulses and period count.
// ---------------------------------------------------------------------------
module tb_ls74163_divider_ctrl;

  localparam int STAGES = 2;

`ifdef LS74163_CTRL_ONESHOT_EN
  localparam bit OS_EN = 1'b1;
`else
  localparam bit OS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ls74163_divider_ctrl_if #(.STAGES(STAGES)) bus ();

  ls74163_divider_ctrl #(.STAGES(STAGES)) dut (
    .CLK     (clk),
    .RESET_L (rst_n),
    .bus     (bus.slave)
  );

  // Two LS74163 stages: synchronous clear, then load, then count.
  logic [7:0] cnt;
  assign bus.Q = cnt;

  always @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!bus.CLR_L)                    cnt[4*k +: 4] <= 4'h0;
      else if (!bus.LD_L)                cnt[4*k +: 4] <= bus.LOAD_D[4*k +: 4];
      else if (bus.ENP && bus.ENT[k])    cnt[4*k +: 4] <= cnt[4*k +: 4] + 4'h1;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run with the given preset/mode and follow it for n RUN cycles.
  // Cycle i counts from the first RUN cycle (Q == preset).
  task automatic run(input logic [7:0] preset, input bit mode, input int n);
    int         len;
    bit         os, erun, etc, edone, eenp, eldl;
    int         eper;
    logic [7:0] eq;
    logic [1:0] eent;
    len = 256 - int'(preset);
    os  = mode && OS_EN;
    bus.PRESET       = preset;
    bus.MODE_ONESHOT = mode;
    bus.START        = 1'b1;
    step();
    bus.START  = 1'b0;
    bus.PRESET = 8'($urandom);
    chk("load_ld_l", bus.LD_L,   1'b0);
    chk("load_busy", bus.BUSY,   1'b1);
    chk("load_enp",  bus.ENP,    1'b0);
    chk("load_done", bus.DONE,   1'b0);
    chk("load_d",    bus.LOAD_D, preset);
    step();
    for (int i = 0; i < n; i++) begin
      if (os) begin
        erun  = (i < len);
        eq    = erun ? 8'(int'(preset) + i) : 8'hFF;
        etc   = (i == len - 1);
        edone = !erun;
        eenp  = (i < len - 1);
        eper  = erun ? 0 : 1;
        eldl  = 1'b1;
      end else begin
        erun  = 1'b1;
        eq    = 8'(int'(preset) + (i % len));
        etc   = ((i % len) == len - 1);
        edone = 1'b0;
        eenp  = 1'b1;
        eper  = (i / len > 255) ? 255 : i / len;
        eldl  = !etc;
      end
      eent = erun ? {(eq[3:0] == 4'hF), 1'b1} : 2'b00;
      chk("q",       bus.Q,       eq);
      chk("tc",      bus.TC,      etc);
      chk("ld_l",    bus.LD_L,    eldl);
      chk("enp",     bus.ENP,     eenp);
      chk("ent",     bus.ENT,     eent);
      chk("busy",    bus.BUSY,    erun);
      chk("done",    bus.DONE,    edone);
      chk("periods", bus.PERIODS, eper);
      chk("load_d",  bus.LOAD_D,  preset);
      step();
    end
  endtask

  task automatic stop_clear();
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    chk("stop_clr_l", bus.CLR_L, 1'b0);
    chk("stop_busy",  bus.BUSY,  1'b0);
    chk("stop_enp",   bus.ENP,   1'b0);
    chk("stop_tc",    bus.TC,    1'b0);
    step();
    chk("idle_clr_l", bus.CLR_L, 1'b1);
    chk("idle_q",     bus.Q,     8'h00);
    chk("idle_busy",  bus.BUSY,  1'b0);
    chk("idle_ld_l",  bus.LD_L,  1'b1);
    step();
    chk("idle_hold_ld_l", bus.LD_L, 1'b1);
    chk("idle_hold_q",    bus.Q,    8'h00);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_clr_l"},   bus.CLR_L,   1'b0);
    chk({pfx, "_ld_l"},    bus.LD_L,    1'b1);
    chk({pfx, "_load_d"},  bus.LOAD_D,  8'h00);
    chk({pfx, "_enp"},     bus.ENP,     1'b0);
    chk({pfx, "_ent"},     bus.ENT,     2'b00);
    chk({pfx, "_tc"},      bus.TC,      1'b0);
    chk({pfx, "_busy"},    bus.BUSY,    1'b0);
    chk({pfx, "_done"},    bus.DONE,    1'b0);
    chk({pfx, "_periods"}, bus.PERIODS, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START        = 1'b0;
    bus.STOP         = 1'b0;
    bus.MODE_ONESHOT = 1'b0;
    bus.PRESET       = 8'h00;
    cnt              = 8'($urandom);
    rst_n            = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    chk("rst_q_cleared", bus.Q, 8'h00);
    rst_n = 1'b1;
    step();
    chk("post_rst_clr_l", bus.CLR_L, 1'b1);
    chk("post_rst_q",     bus.Q,     8'h00);
    chk("post_rst_busy",  bus.BUSY,  1'b0);

    // Periodic divide-by-10, three full periods.
    run(8'hF6, 1'b0, 30);
    chk("f6_periods_3", bus.PERIODS, 8'd3);
    stop_clear();

    // One-shot (or, without the feature, MODE_ONESHOT ignored).
    run(8'hFD, 1'b1, 25);
`ifdef LS74163_CTRL_ONESHOT_EN
    chk("os_done_hold", bus.DONE, 1'b1);
    chk("os_q_hold",    bus.Q,    8'hFF);
    run(8'hFD, 1'b1, 25);
`endif
    stop_clear();

    // STOP together with START at Q=23.
    run(8'h20, 1'b0, 3);
    chk("pre_stop_q", bus.Q, 8'h23);
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    step();
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    chk("ss_clr_l", bus.CLR_L, 1'b0);
    chk("ss_busy",  bus.BUSY,  1'b0);
    step();
    chk("ss_q",     bus.Q,     8'h00);
    chk("ss_clr_h", bus.CLR_L, 1'b1);
    chk("ss_busy2", bus.BUSY,  1'b0);
    chk("ss_ld_l",  bus.LD_L,  1'b1);

    // Cascade carry across the nibble boundary.
    run(8'h0E, 1'b0, 20);
    stop_clear();

    // Asynchronous reset mid-run.
    run(8'h7C, 1'b0, 4);
    chk("pre_rst_q", bus.Q, 8'h80);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    step();
    chk("rel_q",     bus.Q,     8'h00);
    chk("rel_clr_l", bus.CLR_L, 1'b1);
    chk("rel_busy",  bus.BUSY,  1'b0);
    chk("rel_ld_l",  bus.LD_L,  1'b1);

    // TC every cycle and PERIODS saturation.
    run(8'hFF, 1'b0, 300);
    chk("ff_periods_sat", bus.PERIODS, 8'd255);
    stop_clear();

    // Randomised presets, modes and run lengths.
    repeat (5) begin
      run(8'($urandom_range(8'hB0, 8'hFF)), 1'($urandom_range(0, 1)),
          int'($urandom_range(10, 90)));
      stop_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_ls74163_divider_ctrl
